// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer and the ALU result mux:
// 4-bit op codes, 12-bit one-hot mux selects and sequencer FSM states.
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_OR      = 4'd1;
  localparam logic [3:0] OP_NOT     = 4'd2;
  localparam logic [3:0] OP_XOR     = 4'd3;
  localparam logic [3:0] OP_NAND    = 4'd4;
  localparam logic [3:0] OP_NOR     = 4'd5;
  localparam logic [3:0] OP_XNOR    = 4'd6;
  localparam logic [3:0] OP_ADD     = 4'd7;
  localparam logic [3:0] OP_SUB     = 4'd8;
  localparam logic [3:0] OP_SHRIGHT = 4'd9;
  localparam logic [3:0] OP_SHLEFT  = 4'd10;
  localparam logic [3:0] OP_CLEAR   = 4'd11;

  localparam logic [11:0] SEL_AND     = 12'h001;
  localparam logic [11:0] SEL_OR      = 12'h002;
  localparam logic [11:0] SEL_NOT     = 12'h004;
  localparam logic [11:0] SEL_XOR     = 12'h008;
  localparam logic [11:0] SEL_NAND    = 12'h010;
  localparam logic [11:0] SEL_NOR     = 12'h020;
  localparam logic [11:0] SEL_XNOR    = 12'h040;
  localparam logic [11:0] SEL_ADD     = 12'h080;
  localparam logic [11:0] SEL_SUB     = 12'h100;
  localparam logic [11:0] SEL_SHRIGHT = 12'h200;
  localparam logic [11:0] SEL_SHLEFT  = 12'h400;
  localparam logic [11:0] SEL_CLEAR   = 12'h800;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational op decoder: 4-bit op code to one-hot ALU mux select,
// with an illegal flag for the unused codes 12..15 (select stays zero).
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [3:0]  op_i,
  output logic [11:0] sel_o,
  output logic        illegal_o
);

  // Map each legal op to its single select bit; anything else is illegal.
  always_comb begin
    sel_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:     sel_o = SEL_AND;
      OP_OR:      sel_o = SEL_OR;
      OP_NOT:     sel_o = SEL_NOT;
      OP_XOR:     sel_o = SEL_XOR;
      OP_NAND:    sel_o = SEL_NAND;
      OP_NOR:     sel_o = SEL_NOR;
      OP_XNOR:    sel_o = SEL_XNOR;
      OP_ADD:     sel_o = SEL_ADD;
      OP_SUB:     sel_o = SEL_SUB;
      OP_SHRIGHT: sel_o = SEL_SHRIGHT;
      OP_SHLEFT:  sel_o = SEL_SHLEFT;
      OP_CLEAR:   sel_o = SEL_CLEAR;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-level sequencer for the ALU result mux: accepts one op per
// handshake, drives operands and a one-hot select for ALU_LAT cycles,
// captures the mux result into the accumulator and returns a response.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [11:0]      alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [11:0]      sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, data_q, data_d;
  logic             zero_q, zero_d, neg_q, neg_d, err_q, err_d;

  logic [11:0]      dec_sel;
  logic             dec_illegal;
  logic [WIDTH-1:0] cap_w;

  alu_op_decode u_decode (
    .op_i      (cmd_op),
    .sel_o     (dec_sel),
    .illegal_o (dec_illegal)
  );

  // CLEAR ignores whatever the mux presents and captures zero.
  assign cap_w = (sel_q == SEL_CLEAR) ? '0 : alu_res;

  // Next-state logic: accept in IDLE, count settle cycles in ISSUE,
  // hold the response in RESP until the consumer takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && rdy_q) begin
          a_d   = cmd_use_acc ? acc_q : cmd_a;
          b_d   = cmd_b;
          sel_d = dec_sel;
          if (dec_illegal) begin
            data_d  = '0;
            zero_d  = 1'b1;
            neg_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == 4'd0) begin
          data_d  = cap_w;
          acc_d   = cap_w;
          zero_d  = (cap_w == '0);
          neg_d   = cap_w[WIDTH-1];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = (state_q == ST_ISSUE) ? sel_q : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_neg   = neg_q;
  assign rsp_err   = err_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each driving its own behavioural ALU mux.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        cmd_valid [2];
  logic        cmd_use_acc [2];
  logic        rsp_ready [2];
  logic [3:0]  cmd_op [2];
  logic [15:0] cmd_a [2];
  logic [15:0] cmd_b [2];
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic        rsp_zero [2];
  logic        rsp_neg [2];
  logic        rsp_err [2];
  logic [15:0] alu_a [2];
  logic [15:0] alu_b [2];
  logic [15:0] alu_res [2];
  logic [15:0] rsp_data [2];
  logic [15:0] acc [2];
  logic [11:0] alu_sel [2];

  logic [15:0] acc_m [2];
  int n_cmp = 0;
  int n_fail = 0;

  alu_op_sequencer #(.WIDTH(16), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_use_acc(cmd_use_acc[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_res(alu_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_zero(rsp_zero[0]), .rsp_neg(rsp_neg[0]), .rsp_err(rsp_err[0]), .acc(acc[0]));

  alu_op_sequencer #(.WIDTH(16), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_use_acc(cmd_use_acc[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_res(alu_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_zero(rsp_zero[1]), .rsp_neg(rsp_neg[1]), .rsp_err(rsp_err[1]), .acc(acc[1]));

  // Operation semantics by op code (shifts move by one bit).
  function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return ~a;
      4'd3:  return a ^ b;
      4'd4:  return ~(a & b);
      4'd5:  return ~(a | b);
      4'd6:  return ~(a ^ b);
      4'd7:  return a + b;
      4'd8:  return a - b;
      4'd9:  return a >> 1;
      4'd10: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU mux; CLEAR returns junk so the forced zero is visible.
  function automatic logic [15:0] alu_model(input logic [11:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = 16'hDEAD;
    for (int i = 0; i < 11; i++)
      if (s == (12'd1 << i)) r = ref_op(4'(i), a, b);
    if (s == 12'h800) r = 16'hBEEF;
    return r;
  endfunction

  assign alu_res[0] = alu_model(alu_sel[0], alu_a[0], alu_b[0]);
  assign alu_res[1] = alu_model(alu_sel[1], alu_a[1], alu_b[1]);

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one command on instance k, hold the response for `hold` cycles,
  // then hand it off; reports what the DUT returned.
  task automatic do_cmd(input int k, input logic [3:0] op, input logic ua,
                        input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] d, output logic z, output logic n, output logic e,
                        output logic [15:0] av, output int nsel, output logic [11:0] sel, output int lat);
    int t;
    t = 0;
    while (!cmd_ready[k] && t < 20) begin @(negedge clk); t++; end
    if (!cmd_ready[k]) chk("cmd_ready_timeout", 0, 1);
    cmd_valid[k] = 1'b1; cmd_op[k] = op; cmd_use_acc[k] = ua;
    cmd_a[k] = a; cmd_b[k] = b; rsp_ready[k] = 1'b0;
    @(negedge clk);
    cmd_valid[k] = 1'b0; cmd_op[k] = 4'($urandom); cmd_use_acc[k] = 1'($urandom);
    cmd_a[k] = 16'($urandom); cmd_b[k] = 16'($urandom);
    nsel = 0; sel = '0; t = 0;
    while (!rsp_valid[k] && t < 40) begin
      if (alu_sel[k] != 12'h000) begin nsel++; sel = alu_sel[k]; end
      chk("cmd_ready_busy", {31'd0, cmd_ready[k]}, 0);
      @(negedge clk); t++;
    end
    lat = t;
    if (!rsp_valid[k]) chk("rsp_timeout", 0, 1);
    d = rsp_data[k]; z = rsp_zero[k]; n = rsp_neg[k]; e = rsp_err[k]; av = acc[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid[k]}, 1);
      chk("hold_data", {16'd0, rsp_data[k]}, {16'd0, d});
      chk("hold_cmd_ready", {31'd0, cmd_ready[k]}, 0);
      chk("hold_sel", {20'd0, alu_sel[k]}, 0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid[k]}, 0);
    chk("cmd_ready_back", {31'd0, cmd_ready[k]}, 1);
  endtask

  // Command checked against the reference model kept in acc_m.
  task automatic check_txn(input int k, input logic [3:0] op, input logic ua,
                           input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] d, av, ea, er;
    logic z, n, e, legal;
    logic [11:0] sel, es;
    int nsel, lat;
    legal = (op < 4'd12);
    ea = ua ? acc_m[k] : a;
    er = (!legal || op == 4'd11) ? 16'h0000 : ref_op(op, ea, b);
    es = legal ? (12'd1 << op) : 12'd0;
    do_cmd(k, op, ua, a, b, hold, d, z, n, e, av, nsel, sel, lat);
    if (legal) acc_m[k] = er;
    chk("data", {16'd0, d}, {16'd0, er});
    chk("zero", {31'd0, z}, {31'd0, er == 16'h0000});
    chk("neg", {31'd0, n}, {31'd0, er[15]});
    chk("err", {31'd0, e}, {31'd0, !legal});
    chk("acc", {16'd0, av}, {16'd0, acc_m[k]});
    chk("sel", {20'd0, sel}, {20'd0, es});
    chk("sel_cycles", nsel, legal ? lat_of(k) : 0);
    chk("latency", lat, legal ? lat_of(k) : 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        ua;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        z;
    logic        n;
    logic        e;
    logic [15:0] av;
    logic [11:0] sel;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] d, av;
    logic z, n, e;
    logic [11:0] sel;
    int nsel, lat;

    tbl[0] = '{4'd7,  1'b0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0, 1'b0, 16'h2143, 12'h080};
    tbl[1] = '{4'd8,  1'b1, 16'h9999, 16'h2143, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h100};
    tbl[2] = '{4'd8,  1'b1, 16'h9999, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'hFFFF, 12'h100};
    tbl[3] = '{4'd13, 1'b0, 16'h5555, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 12'h000};
    tbl[4] = '{4'd11, 1'b0, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h800};
    tbl[5] = '{4'd1,  1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 16'h0FF0, 12'h002};
    tbl[6] = '{4'd2,  1'b1, 16'h1111, 16'h2222, 16'hF00F, 1'b0, 1'b1, 1'b0, 16'hF00F, 12'h004};
    tbl[7] = '{4'd10, 1'b1, 16'h0000, 16'h0000, 16'hE01E, 1'b0, 1'b1, 1'b0, 16'hE01E, 12'h400};
    tbl[8] = '{4'd15, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hE01E, 12'h000};
    tbl[9] = '{4'd9,  1'b1, 16'h0000, 16'h0000, 16'h700F, 1'b0, 1'b0, 1'b0, 16'h700F, 12'h200};

    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_use_acc[k] = 1'b0; rsp_ready[k] = 1'b0;
      cmd_op[k] = 4'd0; cmd_a[k] = 16'd0; cmd_b[k] = 16'd0; acc_m[k] = 16'd0;
    end

    // Reset state while reset is held.
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready[0]}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 0);
    chk("rst_sel", {20'd0, alu_sel[0]}, 0);
    chk("rst_acc", {16'd0, acc[0]}, 0);
    chk("rst_data", {16'd0, rsp_data[0]}, 0);
    chk("rst_flags", {29'd0, rsp_zero[0], rsp_neg[0], rsp_err[0]}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", {31'd0, cmd_ready[0]}, 1);

    // Directed vectors on the ALU_LAT=1 instance.
    for (int i = 0; i < 10; i++) begin
      do_cmd(0, tbl[i].op, tbl[i].ua, tbl[i].a, tbl[i].b, i % 3, d, z, n, e, av, nsel, sel, lat);
      chk($sformatf("tbl%0d_data", i), {16'd0, d}, {16'd0, tbl[i].d});
      chk($sformatf("tbl%0d_flags", i), {29'd0, z, n, e}, {29'd0, tbl[i].z, tbl[i].n, tbl[i].e});
      chk($sformatf("tbl%0d_acc", i), {16'd0, av}, {16'd0, tbl[i].av});
      chk($sformatf("tbl%0d_sel", i), {20'd0, sel}, {20'd0, tbl[i].sel});
      chk($sformatf("tbl%0d_nsel", i), nsel, tbl[i].e ? 0 : 1);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].e ? 0 : 1);
      acc_m[0] = tbl[i].av;
    end

    // Back-pressure with ALU_LAT=3: response held five cycles.
    check_txn(1, 4'd7, 1'b0, 16'h0003, 16'h0004, 5);
    check_txn(1, 4'd11, 1'b0, 16'h0003, 16'h0004, 5);

    // Randomized commands on both instances.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 150; i++)
        check_txn(k, 4'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 2));

    // Make sure the accumulator is non-zero before aborting with reset.
    check_txn(1, 4'd1, 1'b0, 16'hA5A5, 16'h0101, 0);

    // Reset in the middle of ISSUE aborts the command.
    cmd_valid[1] = 1'b1; cmd_op[1] = 4'd7; cmd_use_acc[1] = 1'b0;
    cmd_a[1] = 16'h0010; cmd_b[1] = 16'h0020;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_pre_sel", {20'd0, alu_sel[1]}, 32'h080);
    reset_n = 1'b0;
    #1;
    chk("abort_sel", {20'd0, alu_sel[1]}, 0);
    chk("abort_rsp_valid", {31'd0, rsp_valid[1]}, 0);
    chk("abort_acc", {16'd0, acc[1]}, 0);
    chk("abort_cmd_ready", {31'd0, cmd_ready[1]}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    acc_m[0] = 16'd0; acc_m[1] = 16'd0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", {31'd0, cmd_ready[1]}, 1);
    chk("abort_no_rsp", {31'd0, rsp_valid[1]}, 0);
    rsp_ready[1] = 1'b0;

    // Accumulator restarts from zero after the abort.
    check_txn(1, 4'd7, 1'b1, 16'h7777, 16'h0005, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
